// File: rtl/tlb_array.sv
// tlb_array: TLB entry storage for the writeback-stage TLB interface.
// Provides one write port, one combinational read port, two combinational
// search ports and a multi-cycle INVTLB walker.
// Optional feature macro: TLB_HITCNT_EN adds per-port hit/miss counters.
module tlb_array #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            rst,
  // search port 0 (fetch)
  input  logic            s0_req,
  input  logic [18:0]     s0_vppn,
  input  logic            s0_va_bit12,
  input  logic [9:0]      s0_asid,
  output logic            s0_found,
  output logic [IDXW-1:0] s0_index,
  output logic [19:0]     s0_ppn,
  output logic [5:0]      s0_ps,
  output logic [1:0]      s0_plv,
  output logic [1:0]      s0_mat,
  output logic            s0_d,
  output logic            s0_v,
  // search port 1 (memory / TLBSRCH)
  input  logic            s1_req,
  input  logic [18:0]     s1_vppn,
  input  logic            s1_va_bit12,
  input  logic [9:0]      s1_asid,
  output logic            s1_found,
  output logic [IDXW-1:0] s1_index,
  output logic [19:0]     s1_ppn,
  output logic [5:0]      s1_ps,
  output logic [1:0]      s1_plv,
  output logic [1:0]      s1_mat,
  output logic            s1_d,
  output logic            s1_v,
  // write port
  input  logic            we,
  input  logic [IDXW-1:0] w_index,
  input  logic            w_e,
  input  logic [18:0]     w_vppn,
  input  logic [5:0]      w_ps,
  input  logic [9:0]      w_asid,
  input  logic            w_g,
  input  logic [19:0]     w_ppn0,
  input  logic [1:0]      w_plv0,
  input  logic [1:0]      w_mat0,
  input  logic            w_d0,
  input  logic            w_v0,
  input  logic [19:0]     w_ppn1,
  input  logic [1:0]      w_plv1,
  input  logic [1:0]      w_mat1,
  input  logic            w_d1,
  input  logic            w_v1,
  // read port
  input  logic [IDXW-1:0] r_index,
  output logic            r_e,
  output logic [18:0]     r_vppn,
  output logic [5:0]      r_ps,
  output logic [9:0]      r_asid,
  output logic            r_g,
  output logic [19:0]     r_ppn0,
  output logic [1:0]      r_plv0,
  output logic [1:0]      r_mat0,
  output logic            r_d0,
  output logic            r_v0,
  output logic [19:0]     r_ppn1,
  output logic [1:0]      r_plv1,
  output logic [1:0]      r_mat1,
  output logic            r_d1,
  output logic            r_v1,
  // INVTLB engine
  input  logic            inv_valid,
  output logic            inv_ready,
  input  logic [4:0]      inv_op,
  input  logic [9:0]      inv_asid,
  input  logic [18:0]     inv_vppn,
  output logic            inv_done,
  output logic            inv_err
`ifdef TLB_HITCNT_EN
  ,
  output logic [31:0]     s0_hit_cnt,
  output logic [31:0]     s0_miss_cnt,
  output logic [31:0]     s1_hit_cnt,
  output logic [31:0]     s1_miss_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_DONE} inv_state_t;

  // entry storage; only E is reset
  logic [TLBNUM-1:0] r_ent_e;
  logic [18:0]       r_ent_vppn [TLBNUM];
  logic [5:0]        r_ent_ps   [TLBNUM];
  logic [9:0]        r_ent_asid [TLBNUM];
  logic              r_ent_g    [TLBNUM];
  logic [19:0]       r_ent_ppn0 [TLBNUM];
  logic [1:0]        r_ent_plv0 [TLBNUM];
  logic [1:0]        r_ent_mat0 [TLBNUM];
  logic              r_ent_d0   [TLBNUM];
  logic              r_ent_v0   [TLBNUM];
  logic [19:0]       r_ent_ppn1 [TLBNUM];
  logic [1:0]        r_ent_plv1 [TLBNUM];
  logic [1:0]        r_ent_mat1 [TLBNUM];
  logic              r_ent_d1   [TLBNUM];
  logic              r_ent_v1   [TLBNUM];

  logic [TLBNUM-1:0] w_s0_hit;
  logic [TLBNUM-1:0] w_s1_hit;
  logic [IDXW-1:0]   w_s0_sel;
  logic [IDXW-1:0]   w_s1_sel;
  logic              w_s0_pg;
  logic              w_s1_pg;

  inv_state_t        r_state;
  inv_state_t        w_next;
  logic [IDXW-1:0]   r_cnt;
  logic [4:0]        r_inv_op;
  logic [9:0]        r_inv_asid;
  logic [18:0]       r_inv_vppn;
  logic              r_err;
  logic              w_accept;
  logic              w_walk_g;
  logic              w_walk_asid_eq;
  logic              w_walk_vm;
  logic              w_walk_sel;
  logic              w_inv_clr;

  // 4KB pages compare the whole VPPN, 4MB pages only the upper 10 bits
  function automatic logic f_vppn_match(input logic [5:0] ps, input logic [18:0] ev,
                                        input logic [18:0] qv);
    if (ps == 6'd12) return ev == qv;
    return ev[18:9] == qv[18:9];
  endfunction

  // per-entry hit vectors for both search ports
  always_comb begin
    w_s0_hit = '0;
    w_s1_hit = '0;
    for (int unsigned i = 0; i < TLBNUM; i++) begin
      w_s0_hit[i] = r_ent_e[i] && (r_ent_g[i] || (r_ent_asid[i] == s0_asid)) &&
                    f_vppn_match(r_ent_ps[i], r_ent_vppn[i], s0_vppn);
      w_s1_hit[i] = r_ent_e[i] && (r_ent_g[i] || (r_ent_asid[i] == s1_asid)) &&
                    f_vppn_match(r_ent_ps[i], r_ent_vppn[i], s1_vppn);
    end
  end

  // priority pick: scanning from the top down lets the lowest hit index win
  always_comb begin
    w_s0_sel = '0;
    w_s1_sel = '0;
    for (int unsigned i = 0; i < TLBNUM; i++) begin
      if (w_s0_hit[TLBNUM-1-i]) w_s0_sel = IDXW'(TLBNUM-1-i);
      if (w_s1_hit[TLBNUM-1-i]) w_s1_sel = IDXW'(TLBNUM-1-i);
    end
  end

  // search port 0 result; everything zero on a miss
  always_comb begin
    s0_found = |w_s0_hit;
    w_s0_pg  = (r_ent_ps[w_s0_sel] == 6'd12) ? s0_va_bit12 : s0_vppn[8];
    s0_index = '0;
    s0_ppn   = '0;
    s0_ps    = '0;
    s0_plv   = '0;
    s0_mat   = '0;
    s0_d     = 1'b0;
    s0_v     = 1'b0;
    if (s0_found) begin
      s0_index = w_s0_sel;
      s0_ps    = r_ent_ps[w_s0_sel];
      s0_ppn   = w_s0_pg ? r_ent_ppn1[w_s0_sel] : r_ent_ppn0[w_s0_sel];
      s0_plv   = w_s0_pg ? r_ent_plv1[w_s0_sel] : r_ent_plv0[w_s0_sel];
      s0_mat   = w_s0_pg ? r_ent_mat1[w_s0_sel] : r_ent_mat0[w_s0_sel];
      s0_d     = w_s0_pg ? r_ent_d1[w_s0_sel]   : r_ent_d0[w_s0_sel];
      s0_v     = w_s0_pg ? r_ent_v1[w_s0_sel]   : r_ent_v0[w_s0_sel];
    end
  end

  // search port 1 result; everything zero on a miss
  always_comb begin
    s1_found = |w_s1_hit;
    w_s1_pg  = (r_ent_ps[w_s1_sel] == 6'd12) ? s1_va_bit12 : s1_vppn[8];
    s1_index = '0;
    s1_ppn   = '0;
    s1_ps    = '0;
    s1_plv   = '0;
    s1_mat   = '0;
    s1_d     = 1'b0;
    s1_v     = 1'b0;
    if (s1_found) begin
      s1_index = w_s1_sel;
      s1_ps    = r_ent_ps[w_s1_sel];
      s1_ppn   = w_s1_pg ? r_ent_ppn1[w_s1_sel] : r_ent_ppn0[w_s1_sel];
      s1_plv   = w_s1_pg ? r_ent_plv1[w_s1_sel] : r_ent_plv0[w_s1_sel];
      s1_mat   = w_s1_pg ? r_ent_mat1[w_s1_sel] : r_ent_mat0[w_s1_sel];
      s1_d     = w_s1_pg ? r_ent_d1[w_s1_sel]   : r_ent_d0[w_s1_sel];
      s1_v     = w_s1_pg ? r_ent_v1[w_s1_sel]   : r_ent_v0[w_s1_sel];
    end
  end

  // combinational read port
  always_comb begin
    r_e    = r_ent_e[r_index];
    r_vppn = r_ent_vppn[r_index];
    r_ps   = r_ent_ps[r_index];
    r_asid = r_ent_asid[r_index];
    r_g    = r_ent_g[r_index];
    r_ppn0 = r_ent_ppn0[r_index];
    r_plv0 = r_ent_plv0[r_index];
    r_mat0 = r_ent_mat0[r_index];
    r_d0   = r_ent_d0[r_index];
    r_v0   = r_ent_v0[r_index];
    r_ppn1 = r_ent_ppn1[r_index];
    r_plv1 = r_ent_plv1[r_index];
    r_mat1 = r_ent_mat1[r_index];
    r_d1   = r_ent_d1[r_index];
    r_v1   = r_ent_v1[r_index];
  end

  // non-E entry fields: plain write, no reset
  always_ff @(posedge clk) begin
    if (we) begin
      r_ent_vppn[w_index] <= w_vppn;
      r_ent_ps[w_index]   <= w_ps;
      r_ent_asid[w_index] <= w_asid;
      r_ent_g[w_index]    <= w_g;
      r_ent_ppn0[w_index] <= w_ppn0;
      r_ent_plv0[w_index] <= w_plv0;
      r_ent_mat0[w_index] <= w_mat0;
      r_ent_d0[w_index]   <= w_d0;
      r_ent_v0[w_index]   <= w_v0;
      r_ent_ppn1[w_index] <= w_ppn1;
      r_ent_plv1[w_index] <= w_plv1;
      r_ent_mat1[w_index] <= w_mat1;
      r_ent_d1[w_index]   <= w_d1;
      r_ent_v1[w_index]   <= w_v1;
    end
  end

  // E bits: reset clears, walker clears, a write to the same entry wins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ent_e <= '0;
    end else begin
      if (w_inv_clr) r_ent_e[r_cnt] <= 1'b0;
      if (we)        r_ent_e[w_index] <= w_e;
    end
  end

  // walker: does the entry under r_cnt satisfy the latched op's condition
  always_comb begin
    w_walk_g       = r_ent_g[r_cnt];
    w_walk_asid_eq = r_ent_asid[r_cnt] == r_inv_asid;
    w_walk_vm      = f_vppn_match(r_ent_ps[r_cnt], r_ent_vppn[r_cnt], r_inv_vppn);
    case (r_inv_op)
      5'd0, 5'd1: w_walk_sel = 1'b1;
      5'd2:       w_walk_sel = w_walk_g;
      5'd3:       w_walk_sel = !w_walk_g;
      5'd4:       w_walk_sel = !w_walk_g && w_walk_asid_eq;
      5'd5:       w_walk_sel = !w_walk_g && w_walk_asid_eq && w_walk_vm;
      5'd6:       w_walk_sel = (w_walk_g || w_walk_asid_eq) && w_walk_vm;
      default:    w_walk_sel = 1'b0;
    endcase
    w_inv_clr = (r_state == S_WALK) && w_walk_sel;
  end

  // INVTLB state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // INVTLB next state; the DONE cycle is not busy, so it may accept too
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) w_next = (inv_op > 5'd6) ? S_DONE : S_WALK;
        else          w_next = S_IDLE;
      end
      S_WALK: if (r_cnt == IDXW'(TLBNUM-1)) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // INVTLB outputs
  always_comb begin
    inv_ready = (r_state != S_WALK);
    inv_done  = (r_state == S_DONE);
    inv_err   = (r_state == S_DONE) && r_err;
    w_accept  = inv_valid && inv_ready;
  end

  // INVTLB operand latch and walk counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_inv_op   <= inv_op;
      r_inv_asid <= inv_asid;
      r_inv_vppn <= inv_vppn;
      r_cnt      <= '0;
      r_err      <= inv_op > 5'd6;
    end else if (r_state == S_WALK) begin
      r_cnt <= r_cnt + IDXW'(1);
    end
  end

`ifdef TLB_HITCNT_EN
  logic [31:0] r_s0_hit;
  logic [31:0] r_s0_miss;
  logic [31:0] r_s1_hit;
  logic [31:0] r_s1_miss;

  // hit/miss statistics on qualified search cycles, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0_hit  <= '0;
      r_s0_miss <= '0;
      r_s1_hit  <= '0;
      r_s1_miss <= '0;
    end else begin
      if (s0_req) begin
        if (s0_found) r_s0_hit  <= r_s0_hit + 32'd1;
        else          r_s0_miss <= r_s0_miss + 32'd1;
      end
      if (s1_req) begin
        if (s1_found) r_s1_hit  <= r_s1_hit + 32'd1;
        else          r_s1_miss <= r_s1_miss + 32'd1;
      end
    end
  end

  assign s0_hit_cnt  = r_s0_hit;
  assign s0_miss_cnt = r_s0_miss;
  assign s1_hit_cnt  = r_s1_hit;
  assign s1_miss_cnt = r_s1_miss;
`else
  logic w_unused;
  assign w_unused = s0_req ^ s1_req;
`endif

endmodule

// File: tb/tb_tlb_array.sv
// tb_tlb_array: self-checking bench for tlb_array (table vectors, hand
// sequences for INVTLB corner cases, randomized traffic vs. a reference model).
module tb_tlb_array;
  localparam int TLBNUM = 16;

  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic        g;
    logic [19:0] ppn0;
    logic [19:0] ppn1;
    logic [1:0]  plv0;
    logic [1:0]  plv1;
    logic [1:0]  mat0;
    logic [1:0]  mat1;
    logic        d0;
    logic        d1;
    logic        v0;
    logic        v1;
  } ent_t;

  typedef struct packed {
    logic        found;
    logic [3:0]  idx;
    logic [19:0] ppn;
    logic [5:0]  ps;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } sres_t;

  typedef struct {
    logic        do_wr;
    logic [3:0]  widx;
    ent_t        went;
    logic [18:0] svppn;
    logic        sb12;
    logic [9:0]  sasid;
    logic        efound;
    logic [3:0]  eidx;
    logic [19:0] eppn;
    logic        ev;
  } tv_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s0_req = 1'b0, s1_req = 1'b0;
  logic [18:0] s0_vppn = '0, s1_vppn = '0;
  logic s0_va_bit12 = 1'b0, s1_va_bit12 = 1'b0;
  logic [9:0] s0_asid = '0, s1_asid = '0;
  logic s0_found, s1_found;
  logic [3:0] s0_index, s1_index;
  logic [19:0] s0_ppn, s1_ppn;
  logic [5:0] s0_ps, s1_ps;
  logic [1:0] s0_plv, s1_plv, s0_mat, s1_mat;
  logic s0_d, s1_d, s0_v, s1_v;
  logic we = 1'b0;
  logic [3:0] w_index = '0;
  logic w_e = 1'b0, w_g = 1'b0;
  logic [18:0] w_vppn = '0;
  logic [5:0] w_ps = '0;
  logic [9:0] w_asid = '0;
  logic [19:0] w_ppn0 = '0, w_ppn1 = '0;
  logic [1:0] w_plv0 = '0, w_plv1 = '0, w_mat0 = '0, w_mat1 = '0;
  logic w_d0 = 1'b0, w_d1 = 1'b0, w_v0 = 1'b0, w_v1 = 1'b0;
  logic [3:0] r_index = '0;
  logic r_e, r_g, r_d0, r_d1, r_v0, r_v1;
  logic [18:0] r_vppn;
  logic [5:0] r_ps;
  logic [9:0] r_asid;
  logic [19:0] r_ppn0, r_ppn1;
  logic [1:0] r_plv0, r_plv1, r_mat0, r_mat1;
  logic inv_valid = 1'b0;
  logic inv_ready, inv_done, inv_err;
  logic [4:0] inv_op = '0;
  logic [9:0] inv_asid = '0;
  logic [18:0] inv_vppn = '0;
`ifdef TLB_HITCNT_EN
  logic [31:0] s0_hit_cnt, s0_miss_cnt, s1_hit_cnt, s1_miss_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;
  ent_t m_ent [TLBNUM];
  logic [18:0] vpool [4] = '{19'h12345, 19'h12200, 19'h40000, 19'h7F000};
  tv_t tv [7];

  tlb_array #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .rst(rst),
`ifdef TLB_HITCNT_EN
    .s0_hit_cnt(s0_hit_cnt), .s0_miss_cnt(s0_miss_cnt),
    .s1_hit_cnt(s1_hit_cnt), .s1_miss_cnt(s1_miss_cnt),
`endif
    .s0_req(s0_req), .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid),
    .s0_found(s0_found), .s0_index(s0_index), .s0_ppn(s0_ppn), .s0_ps(s0_ps),
    .s0_plv(s0_plv), .s0_mat(s0_mat), .s0_d(s0_d), .s0_v(s0_v),
    .s1_req(s1_req), .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index), .s1_ppn(s1_ppn), .s1_ps(s1_ps),
    .s1_plv(s1_plv), .s1_mat(s1_mat), .s1_d(s1_d), .s1_v(s1_v),
    .we(we), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn), .w_ps(w_ps),
    .w_asid(w_asid), .w_g(w_g),
    .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0), .w_d0(w_d0), .w_v0(w_v0),
    .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid),
    .r_g(r_g),
    .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0), .r_v0(r_v0),
    .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1), .r_v1(r_v1),
    .inv_valid(inv_valid), .inv_ready(inv_ready), .inv_op(inv_op),
    .inv_asid(inv_asid), .inv_vppn(inv_vppn), .inv_done(inv_done), .inv_err(inv_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic ent_t mk_ent(input logic e, input logic [18:0] vppn, input logic [5:0] ps,
                                  input logic [9:0] asid, input logic g, input logic [19:0] p0,
                                  input logic [19:0] p1, input logic v0, input logic v1);
    ent_t x;
    x = '{e: e, vppn: vppn, ps: ps, asid: asid, g: g, ppn0: p0, ppn1: p1,
          plv0: 2'd0, plv1: 2'd3, mat0: 2'd1, mat1: 2'd2, d0: 1'b0, d1: 1'b1, v0: v0, v1: v1};
    return x;
  endfunction

  function automatic ent_t rnd_ent(input logic e);
    ent_t x;
    x.e    = e;
    x.vppn = vpool[$urandom_range(0, 3)];
    x.ps   = ($urandom_range(0, 1) != 0) ? 6'd12 : 6'd21;
    x.asid = 10'($urandom_range(1, 3));
    x.g    = 1'($urandom_range(0, 1));
    x.ppn0 = 20'($urandom);
    x.ppn1 = 20'($urandom);
    x.plv0 = 2'($urandom);
    x.plv1 = 2'($urandom);
    x.mat0 = 2'($urandom);
    x.mat1 = 2'($urandom);
    x.d0   = 1'($urandom);
    x.d1   = 1'($urandom);
    x.v0   = 1'($urandom);
    x.v1   = 1'($urandom);
    return x;
  endfunction

  // same-page test on full virtual addresses: shift away the in-page offset plus
  // the even/odd page-select bit and compare what is left
  function automatic bit same_pair(input ent_t x, input logic [31:0] va);
    logic [31:0] ea;
    int sh;
    ea = {x.vppn, 13'h0};
    sh = int'(x.ps) + 1;
    return (va >> sh) == (ea >> sh);
  endfunction

  function automatic sres_t model_search(input logic [18:0] vppn, input logic b12,
                                         input logic [9:0] asid);
    sres_t r;
    logic [31:0] va;
    logic pg;
    r  = '0;
    va = {vppn, b12, 12'h000};
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (m_ent[i].e && (m_ent[i].g || m_ent[i].asid == asid) && same_pair(m_ent[i], va)) begin
        pg      = va[m_ent[i].ps];
        r.found = 1'b1;
        r.idx   = 4'(i);
        r.ps    = m_ent[i].ps;
        r.ppn   = pg ? m_ent[i].ppn1 : m_ent[i].ppn0;
        r.plv   = pg ? m_ent[i].plv1 : m_ent[i].plv0;
        r.mat   = pg ? m_ent[i].mat1 : m_ent[i].mat0;
        r.d     = pg ? m_ent[i].d1 : m_ent[i].d0;
        r.v     = pg ? m_ent[i].v1 : m_ent[i].v0;
      end
    end
    return r;
  endfunction

  function automatic bit inv_hit(input ent_t x, input logic [4:0] op, input logic [9:0] asid,
                                 input logic [18:0] vppn);
    bit am, vm;
    am = (x.asid == asid);
    vm = same_pair(x, {vppn, 13'h0});
    case (op)
      5'd0, 5'd1: return 1'b1;
      5'd2: return x.g;
      5'd3: return !x.g;
      5'd4: return !x.g && am;
      5'd5: return !x.g && am && vm;
      5'd6: return (x.g || am) && vm;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive_w(input ent_t x);
    w_e = x.e; w_vppn = x.vppn; w_ps = x.ps; w_asid = x.asid; w_g = x.g;
    w_ppn0 = x.ppn0; w_plv0 = x.plv0; w_mat0 = x.mat0; w_d0 = x.d0; w_v0 = x.v0;
    w_ppn1 = x.ppn1; w_plv1 = x.plv1; w_mat1 = x.mat1; w_d1 = x.d1; w_v1 = x.v1;
  endtask

  task automatic wr(input int idx, input ent_t x);
    @(negedge clk);
    we = 1'b1;
    w_index = 4'(idx);
    drive_w(x);
    @(negedge clk);
    we = 1'b0;
    m_ent[idx] = x;
  endtask

  task automatic chk_entry(input int idx);
    r_index = 4'(idx);
    #1;
    chk($sformatf("read_entry%0d", idx),
        {r_e, r_vppn, r_ps, r_asid, r_g, r_ppn0, r_ppn1, r_plv0, r_plv1,
         r_mat0, r_mat1, r_d0, r_d1, r_v0, r_v1}, m_ent[idx]);
  endtask

  task automatic chk_all();
    for (int i = 0; i < TLBNUM; i++) chk_entry(i);
  endtask

  task automatic chk_search(input logic [18:0] v0, input logic b0, input logic [9:0] a0,
                            input logic [18:0] v1, input logic b1, input logic [9:0] a1);
    s0_vppn = v0; s0_va_bit12 = b0; s0_asid = a0;
    s1_vppn = v1; s1_va_bit12 = b1; s1_asid = a1;
    #1;
    chk("search_s0", {s0_found, s0_index, s0_ppn, s0_ps, s0_plv, s0_mat, s0_d, s0_v},
        model_search(v0, b0, a0));
    chk("search_s1", {s1_found, s1_index, s1_ppn, s1_ps, s1_plv, s1_mat, s1_d, s1_v},
        model_search(v1, b1, a1));
  endtask

  function automatic logic [18:0] rnd_vppn();
    logic [18:0] v;
    v = vpool[$urandom_range(0, 3)];
    if ($urandom_range(0, 1) != 0) v[8:0] = 9'($urandom);
    return v;
  endfunction

  // issue one INVTLB; optionally re-poke inv_valid mid-walk and/or write entry 15
  // on the final walk cycle
  task automatic run_inv(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] vppn,
                         input bit poke, input bit wlast);
    int n, lat, low;
    bit seen;
    logic err;
    ent_t wl;
    wl = mk_ent(1'b1, 19'h40000, 6'd12, 10'd2, 1'b1, 20'h0F0F0, 20'h0E0E0, 1'b1, 1'b1);
    @(negedge clk);
    #1;
    chk("inv_ready_before", inv_ready, 1'b1);
    inv_valid = 1'b1; inv_op = op; inv_asid = asid; inv_vppn = vppn;
    @(negedge clk);
    inv_valid = 1'b0; inv_op = 5'd0; inv_asid = ~asid; inv_vppn = ~vppn;
    n = 1; lat = 0; low = 0; seen = 1'b0; err = 1'b0;
    while (!seen && n <= 60) begin
      inv_valid = poke && (n == 3);
      if (wlast && n == TLBNUM) begin
        we = 1'b1; w_index = 4'd15; drive_w(wl);
      end else begin
        we = 1'b0;
      end
      #1;
      if (inv_done) begin
        seen = 1'b1; lat = n; err = inv_err;
      end else begin
        if (!inv_ready) low++;
        @(negedge clk);
        n++;
      end
    end
    we = 1'b0;
    inv_valid = 1'b0;
    chk("inv_latency", 32'(lat), (op > 5'd6) ? 32'd1 : 32'(TLBNUM + 1));
    chk("inv_busy_cycles", 32'(low), (op > 5'd6) ? 32'd0 : 32'(TLBNUM));
    chk("inv_err", err, op > 5'd6);
    if (op <= 5'd6)
      for (int i = 0; i < TLBNUM; i++)
        if (inv_hit(m_ent[i], op, asid, vppn)) m_ent[i].e = 1'b0;
    if (wlast) m_ent[15] = wl;
    @(negedge clk);
    #1;
    chk("inv_done_single", {inv_done, inv_err, inv_ready}, 3'b001);
  endtask

  initial begin
    int dc, nr;
    ent_t ea, eb;
    for (int i = 0; i < TLBNUM; i++) m_ent[i] = '0;
    ea = mk_ent(1'b1, 19'h12345, 6'd12, 10'd5, 1'b0, 20'h11111, 20'hABCDE, 1'b0, 1'b1);
    eb = mk_ent(1'b1, 19'h12200, 6'd21, 10'd9, 1'b1, 20'h22222, 20'h33333, 1'b1, 1'b1);
    tv[0] = '{1'b1, 4'd3, ea, 19'h12345, 1'b1, 10'd5, 1'b1, 4'd3, 20'hABCDE, 1'b1};
    tv[1] = '{1'b0, 4'd0, ea, 19'h12345, 1'b1, 10'd6, 1'b0, 4'd0, 20'h00000, 1'b0};
    tv[2] = '{1'b0, 4'd0, ea, 19'h12345, 1'b0, 10'd5, 1'b1, 4'd3, 20'h11111, 1'b0};
    tv[3] = '{1'b1, 4'd7, eb, 19'h123FF, 1'b0, 10'd1, 1'b1, 4'd7, 20'h33333, 1'b1};
    tv[4] = '{1'b1, 4'd2, eb, 19'h123FF, 1'b0, 10'd1, 1'b1, 4'd2, 20'h33333, 1'b1};
    tv[5] = '{1'b0, 4'd0, eb, 19'h12250, 1'b1, 10'd1, 1'b1, 4'd2, 20'h22222, 1'b1};
    tv[6] = '{1'b0, 4'd0, eb, 19'h12400, 1'b0, 10'd1, 1'b0, 4'd0, 20'h00000, 1'b0};

    // reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_inv", {inv_ready, inv_done, inv_err}, 3'b100);
    chk("reset_s0_found", s0_found, 1'b0);
    r_index = 4'd0;
    #1;
    chk("reset_e0", r_e, 1'b0);
    r_index = 4'd15;
    #1;
    chk("reset_e15", r_e, 1'b0);

    for (int i = 0; i < TLBNUM; i++) wr(i, rnd_ent(1'b0));
    chk_all();

    // directed vector table
    for (int k = 0; k < 7; k++) begin
      if (tv[k].do_wr) wr(int'(tv[k].widx), tv[k].went);
      s0_vppn = tv[k].svppn; s0_va_bit12 = tv[k].sb12; s0_asid = tv[k].sasid;
      #1;
      chk($sformatf("vector%0d", k), {s0_found, s0_index, s0_ppn, s0_v},
          {tv[k].efound, tv[k].eidx, tv[k].eppn, tv[k].ev});
    end

    // INVTLB op=4 asid=5, with a stray request during the walk
    wr(5, mk_ent(1'b1, 19'h7F000, 6'd12, 10'd5, 1'b0, 20'h1, 20'h2, 1'b1, 1'b1));
    wr(6, mk_ent(1'b1, 19'h7F000, 6'd12, 10'd5, 1'b1, 20'h3, 20'h4, 1'b1, 1'b1));
    wr(8, mk_ent(1'b1, 19'h7F000, 6'd12, 10'd6, 1'b0, 20'h5, 20'h6, 1'b1, 1'b1));
    run_inv(5'd4, 10'd5, 19'h0, 1'b1, 1'b0);
    r_index = 4'd3; #1; chk("op4_e3_cleared", r_e, 1'b0);
    r_index = 4'd6; #1; chk("op4_e6_kept", r_e, 1'b1);
    r_index = 4'd8; #1; chk("op4_e8_kept", r_e, 1'b1);
    chk_all();

    // illegal op: immediate done+err, table untouched
    run_inv(5'd9, 10'd5, 19'h0, 1'b0, 1'b0);
    chk_all();

    // write on the last walk cycle beats the clear
    run_inv(5'd0, 10'd0, 19'h0, 1'b0, 1'b1);
    r_index = 4'd15; #1; chk("wlast_e15_kept", r_e, 1'b1);
    r_index = 4'd14; #1; chk("wlast_e14_cleared", r_e, 1'b0);
    chk_all();

    // randomized traffic against the reference model
    for (int it = 0; it < 300; it++) begin
      int sel;
      sel = int'($urandom_range(0, 19));
      if (sel < 7) begin
        wr(int'($urandom_range(0, TLBNUM - 1)), rnd_ent(1'($urandom_range(0, 3) != 0)));
      end else if (sel < 18) begin
        chk_search(rnd_vppn(), 1'($urandom), 10'($urandom_range(1, 3)),
                   rnd_vppn(), 1'($urandom), 10'($urandom_range(1, 3)));
        chk_entry(int'($urandom_range(0, TLBNUM - 1)));
      end else if (sel == 18) begin
        run_inv(5'($urandom_range(0, 6)), 10'($urandom_range(1, 3)), rnd_vppn(), 1'b0, 1'b0);
        chk_all();
      end else begin
        run_inv(5'($urandom_range(7, 31)), 10'd1, 19'h0, 1'b0, 1'b0);
      end
    end

    // reset during the walk: no completion pulse, every entry invalid
    for (int i = 0; i < TLBNUM; i++) wr(i, rnd_ent(1'b1));
    @(negedge clk);
    inv_valid = 1'b1; inv_op = 5'd2; inv_asid = 10'd1; inv_vppn = 19'h0;
    @(negedge clk);
    inv_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dc = 0; nr = 0;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (inv_done) dc++;
      if (!inv_ready) nr++;
      @(negedge clk);
    end
    chk("rst_walk_no_done", 32'(dc), 32'd0);
    chk("rst_walk_ready", 32'(nr), 32'd0);
    for (int i = 0; i < TLBNUM; i++) m_ent[i].e = 1'b0;
    chk_all();
    s0_vppn = vpool[0]; s0_va_bit12 = 1'b0; s0_asid = 10'd1;
    #1;
    chk("rst_walk_miss", s0_found, 1'b0);
    for (int k = 0; k < 8; k++)
      chk_search(rnd_vppn(), 1'($urandom), 10'($urandom_range(1, 3)),
                 rnd_vppn(), 1'($urandom), 10'($urandom_range(1, 3)));

`ifdef TLB_HITCNT_EN
    // 10 qualified s0 searches, 7 of them hitting
    wr(0, mk_ent(1'b1, 19'h0AAAA, 6'd12, 10'd1, 1'b1, 20'h7, 20'h8, 1'b1, 1'b1));
    for (int k = 0; k < 10; k++) begin
      s0_req = 1'b1;
      s0_vppn = (k < 7) ? 19'h0AAAA : 19'h0BBBB;
      @(negedge clk);
    end
    s0_req = 1'b0;
    #1;
    chk("s0_hit_cnt", s0_hit_cnt, 32'd7);
    chk("s0_miss_cnt", s0_miss_cnt, 32'd3);
    chk("s1_cnts_idle", {s1_hit_cnt, s1_miss_cnt}, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
